// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: one-hot op encoding, FSM states,
// access sizes, byte-strobe constants and op decode helpers.
package load_store_unit_pkg;

  typedef enum logic [15:0] {
    LUI   = 16'h0001,
    AUIPC = 16'h0002,
    JAL   = 16'h0004,
    JALR  = 16'h0008,
    BEQ   = 16'h0010,
    BNE   = 16'h0020,
    LB    = 16'h0040,
    LH    = 16'h0080,
    LW    = 16'h0100,
    LBU   = 16'h0200,
    LHU   = 16'h0400,
    SB    = 16'h0800,
    SH    = 16'h1000,
    SW    = 16'h2000,
    ADDI  = 16'h4000,
    ADD   = 16'h8000
  } InstructionSet;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} LsuState;
  typedef enum logic [1:0] {BYTE, HALF, WORD} MemSize;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  typedef struct packed {
    logic   is_load;
    logic   is_store;
    MemSize size;
    logic   is_unsigned;
  } MemOp;

  function automatic MemOp decode_op(input InstructionSet op);
    MemOp m;
    m.is_load     = 1'b0;
    m.is_store    = 1'b0;
    m.size        = WORD;
    m.is_unsigned = 1'b0;
    case (op)
      LB:  begin m.is_load = 1'b1;  m.size = BYTE; end
      LBU: begin m.is_load = 1'b1;  m.size = BYTE; m.is_unsigned = 1'b1; end
      LH:  begin m.is_load = 1'b1;  m.size = HALF; end
      LHU: begin m.is_load = 1'b1;  m.size = HALF; m.is_unsigned = 1'b1; end
      LW:  m.is_load = 1'b1;
      SB:  begin m.is_store = 1'b1; m.size = BYTE; end
      SH:  begin m.is_store = 1'b1; m.size = HALF; end
      SW:  m.is_store = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input MemSize size, input logic [1:0] offset);
    return ((size == HALF) && offset[0]) || ((size == WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store replication/strobes and load
// extraction with sign or zero extension.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  MemSize      size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{offset, 3'b000} +: 8];
    half_sel  = rdata[{offset[1], 4'b0000} +: 16];
    wstrb     = STRB_WORD;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      BYTE: begin
        wstrb     = STRB_BYTE << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      end
      HALF: begin
        wstrb     = STRB_HALF << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one valid/ready memory transaction per start pulse.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  InstructionSet op,
  input  logic [31:0]   addr,
  input  logic [31:0]   store_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   load_data,
  output logic          fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  LsuState          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  MemOp             mop_q, mop_d;
  logic [1:0]       off_q, off_d;
  logic             busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic [31:0]      load_data_q, load_data_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;

  MemOp        mo_live;
  MemSize      sel_size;
  logic        sel_unsigned, misalign_hit, timeout_hit;
  logic [1:0]  sel_offset;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  // Lane logic sees the live request in IDLE (store setup) and the latched one afterwards (load capture).
  always_comb begin
    mo_live      = decode_op(op);
    sel_size     = (state_q == IDLE) ? mo_live.size : mop_q.size;
    sel_unsigned = (state_q == IDLE) ? mo_live.is_unsigned : mop_q.is_unsigned;
    sel_offset   = (state_q == IDLE) ? addr[1:0] : off_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_hit = (mo_live.is_load | mo_live.is_store) & is_misaligned(mo_live.size, addr[1:0]);
`else
    misalign_hit = 1'b0;
`endif
    timeout_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  lsu_lane_align u_align (
    .size       (sel_size),
    .is_unsigned(sel_unsigned),
    .offset     (sel_offset),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mop_d       = mop_q;
    off_d       = off_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: if (start) begin
        mop_d  = mo_live;
        off_d  = addr[1:0];
        busy_d = 1'b1;
        if (!(mo_live.is_load || mo_live.is_store) || misalign_hit) begin
          state_d     = DONE;
          done_d      = 1'b1;
          fault_d     = misalign_hit;
          load_data_d = '0;
        end else begin
          state_d     = REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = mo_live.is_store;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = mo_live.is_store ? al_wdata : '0;
          mem_wstrb_d = mo_live.is_store ? al_wstrb : '0;
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mop_q.is_store || mem_rvalid) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b0;
            if (!mop_q.is_store) load_data_d = al_load;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (timeout_hit) begin
          mem_req_d   = 1'b0;
          state_d     = DONE;
          done_d      = 1'b1;
          fault_d     = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = DONE;
          done_d      = 1'b1;
          fault_d     = 1'b0;
          load_data_d = al_load;
        end else if (timeout_hit) begin
          state_d     = DONE;
          done_d      = 1'b1;
          fault_d     = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mop_q       <= '0;
      off_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mop_q       <= mop_d;
      off_q       <= off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected requests and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  InstructionSet op = ADD;
  logic [31:0]   addr = '0;
  logic [31:0]   store_data = '0;
  logic          busy, done, fault, mem_req, mem_we;
  logic [31:0]   load_data, mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  load_store_unit #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        chk_ld;
    logic [31:0] ld;
    logic        flt;
    int          lat;
    int          s;
  } rsp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  rsp_t mon_r;
  req_t mon_q;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (rsp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no completion", cyc);
        end else begin
          mon_r = rsp_q.pop_front();
          check({mon_r.name, "_fault"}, 32'(fault), 32'(mon_r.flt));
          if (mon_r.chk_ld) check({mon_r.name, "_load_data"}, load_data, mon_r.ld);
          check({mon_r.name, "_latency"}, 32'(cyc - mon_r.s), 32'(mon_r.lat));
        end
      end
      if (mem_req && mem_ready) begin
        if (req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got mem_req accepted addr 0x%08h, required no request", mem_addr);
        end else begin
          mon_q = req_q.pop_front();
          check({mon_q.name, "_we"}, 32'(mem_we), 32'(mon_q.we));
          check({mon_q.name, "_addr"}, mem_addr, mon_q.addr);
          check({mon_q.name, "_wstrb"}, 32'(mem_wstrb), 32'(mon_q.wstrb));
          if (mon_q.we) check({mon_q.name, "_wdata"}, mem_wdata, mon_q.wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input InstructionSet o, input logic [31:0] a, input logic [31:0] sd);
    op = o; addr = a; store_data = sd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 30) begin
      tick();
      k++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got done=0 after %0d cycles, required done=1", nm, k);
    end
    tick();
  endtask

  // rdly: REQ cycles with mem_ready low; vdly: cycles from accept to rvalid (0 = same cycle)
  task automatic access(input string nm, input InstructionSet o, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] ew, input logic [3:0] es,
                        input logic [31:0] rd, input int rdly, input int vdly,
                        input logic [31:0] eld);
    logic is_st;
    is_st = (o == SB) || (o == SH) || (o == SW);
    req_q.push_back('{nm, is_st, {a[31:2], 2'b00}, ew, is_st ? es : 4'b0000});
    rsp_q.push_back('{nm, !is_st, eld, 1'b0, 2 + rdly + (is_st ? 0 : vdly), cyc});
    mem_ready = 1'b0;
    issue(o, a, sd);
    for (int k = 0; k < rdly; k++) begin
      check({nm, "_req_held"}, 32'(mem_req), 32'd1);
      check({nm, "_addr_held"}, mem_addr, {a[31:2], 2'b00});
      start = (k == 1);
      if (k == 1) begin op = SW; addr = 32'hDEAD_0000; end
      tick();
    end
    start = 1'b0;
    mem_ready = 1'b1;
    if (!is_st && vdly == 0) begin mem_rvalid = 1'b1; mem_rdata = rd; end
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    if (!is_st && vdly > 0) begin
      repeat (vdly - 1) tick();
      mem_rvalid = 1'b1; mem_rdata = rd;
      tick();
      mem_rvalid = 1'b0;
    end
    wait_done(nm);
  endtask

  initial begin
    int req_cycles;
    int k;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    reset = 1'b0;
    tick();

    access("sb", SB, 32'h0000_1003, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000, '0, 0, 0, '0);
    access("sh", SH, 32'h0000_1006, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, '0, 0, 0, '0);
    access("lb", LB, 32'h0000_2001, '0, '0, '0, 32'h0000_F000, 0, 3, 32'hFFFF_FFF0);
    access("lbu", LBU, 32'h0000_2001, '0, '0, '0, 32'h0000_F000, 0, 3, 32'h0000_00F0);
    access("lh", LH, 32'h0000_2002, '0, '0, '0, 32'h8001_0000, 4, 1, 32'hFFFF_8001);
    access("lhu", LHU, 32'h0000_2002, '0, '0, '0, 32'h8001_0000, 0, 0, 32'h0000_8001);

`ifdef LSU_MISALIGN_TRAP_EN
    rsp_q.push_back('{"lw_mis", 1'b1, 32'h0, 1'b1, 1, cyc});
    mem_ready = 1'b1;
    issue(LW, 32'h0000_3002, '0);
    check("lw_mis_no_req", 32'(mem_req), 32'd0);
    wait_done("lw_mis");
    mem_ready = 1'b0;
`else
    access("lw_unal", LW, 32'h0000_3002, '0, '0, '0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
`endif

    rsp_q.push_back('{"add_nomem", 1'b1, 32'h0, 1'b0, 1, cyc});
    mem_ready = 1'b1;
    issue(ADD, 32'h0000_5004, 32'h1111_1111);
    wait_done("add_nomem");
    mem_ready = 1'b0;

    rsp_q.push_back('{"timeout", 1'b1, 32'h0, 1'b1, 9, cyc});
    issue(LW, 32'h0000_5000, '0);
    req_cycles = 0;
    k = 0;
    while (!done && k < 30) begin
      if (mem_req) req_cycles++;
      tick();
      k++;
    end
    check("timeout_req_cycles", 32'(req_cycles), 32'd8);
    check("timeout_req_dropped", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    mem_rvalid = 1'b0;
    check("stray_rvalid_busy", 32'(busy), 32'd0);
    check("stray_rvalid_load_data", load_data, 32'd0);

    req_q.push_back('{"lw_rst", 1'b0, 32'h0000_0040, '0, 4'b0000});
    issue(LW, 32'h0000_0040, '0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_load_data", load_data, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    check("late_rvalid_busy", 32'(busy), 32'd0);
    access("sw", SW, 32'h0000_0040, 32'h1234_5678, 32'h1234_5678, 4'b1111, '0, 0, 0, '0);

    repeat (3) tick();
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
